// File: rtl/dadda_final_adder_if.sv
// Handshake and data bundle between the Dadda tree, the final adder and the
// FinalSum packing stage.
//
// Valid/ready: a transfer happens on a rising clk edge when valid && ready.
// The producer holds its payload stable while valid is 1 and not yet taken.
// The consumer may drive ready independently of valid.
interface dadda_final_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] row_a;
  logic [WIDTH-1:0] row_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Environment side: drives the rows and the downstream ready.
  modport master (
    output in_valid, row_a, row_b, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  // Adder side.
  modport slave (
    input  in_valid, row_a, row_b, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/dadda_final_adder.sv
// Two-stage carry-propagate adder that collapses the two reduced Dadda rows
// into the final product. Stage 1 adds the low SPLIT bits and carries the
// untouched high halves forward; stage 2 adds the high halves plus the
// registered low carry. Both stages form an elastic valid/ready pipeline,
// so up to two pairs can be held while downstream stalls.
module dadda_final_adder #(
  parameter int WIDTH = 64,
  parameter int SPLIT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  dadda_final_adder_if.slave    bus
);

  localparam int HW = WIDTH - SPLIT;

  // Pipeline occupancy flags (the only reset state)
  logic             s1_valid;
  logic             out_valid_q;

  // Stage-1 data
  logic [SPLIT-1:0] s1_lo_sum;
  logic             s1_lo_carry;
  logic [HW-1:0]    s1_hi_a;
  logic [HW-1:0]    s1_hi_b;

  // Stage-2 data
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             accept;
  logic             advance;
  logic [SPLIT:0]   lo_full;
  logic [HW:0]      hi_full;

  // Stage 2 can take stage 1's pair when it is empty or emptying this cycle;
  // stage 1 can take a new pair when it is empty or moving into stage 2.
  assign advance    = s1_valid && (!out_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid || !out_valid_q || bus.out_ready;
  assign accept     = bus.in_valid && bus.in_ready;

  assign lo_full = {1'b0, bus.row_a[SPLIT-1:0]} + {1'b0, bus.row_b[SPLIT-1:0]};
  assign hi_full = {1'b0, s1_hi_a} + {1'b0, s1_hi_b} + {{HW{1'b0}}, s1_lo_carry};

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

  // Occupancy flags: set on load, clear when the stage empties without refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept)
        s1_valid <= 1'b1;
      else if (advance)
        s1_valid <= 1'b0;

      if (advance)
        out_valid_q <= 1'b1;
      else if (bus.out_ready)
        out_valid_q <= 1'b0;
    end
  end

  // Stage-1 data load: low partial sum, its carry, raw high halves
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_lo_sum   <= lo_full[SPLIT-1:0];
      s1_lo_carry <= lo_full[SPLIT];
      s1_hi_a     <= bus.row_a[WIDTH-1:SPLIT];
      s1_hi_b     <= bus.row_b[WIDTH-1:SPLIT];
    end
  end

  // Stage-2 data load: finish the high half with the registered low carry
  always_ff @(posedge clk) begin
    if (advance) begin
      sum_q  <= {hi_full[HW-1:0], s1_lo_sum};
      cout_q <= hi_full[HW];
    end
  end

endmodule

// File: tb/tb_dadda_final_adder.sv
// Bench for dadda_final_adder: directed vectors with hand-computed sums,
// latency, backpressure, mid-flight reset and a random stream, all checked
// through an expected-result queue drained by an independent monitor.
module tb_dadda_final_adder;

  localparam int W = 64;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [W:0] exp_q[$];   // {cout, sum}
  logic       rand_ready_en = 1'b0;

  dadda_final_adder_if #(.WIDTH(W)) bus_if ();

  dadda_final_adder #(.WIDTH(W), .SPLIT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one pair, waits (bounded) for in_ready, records the expectation.
  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W:0] exp);
    int waited;
    waited = 0;
    bus_if.in_valid = 1'b1;
    bus_if.row_a    = a;
    bus_if.row_b    = b;
    @(negedge clk);
    while (!bus_if.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus_if.in_ready) begin
      chk("accept_timeout", {{W{1'b0}}, bus_if.in_ready}, {{W{1'b0}}, 1'b1});
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       hold_valid = 1'b0;
  logic [W:0] held;

  always @(negedge clk) begin
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        chk("hold_valid", {{W{1'b0}}, bus_if.out_valid}, {{W{1'b0}}, 1'b1});
        chk("hold_data", {bus_if.cout, bus_if.sum}, held);
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {bus_if.cout, bus_if.sum}, {(W+1){1'bx}});
        end else begin
          chk("result", {bus_if.cout, bus_if.sum}, exp_q.pop_front());
        end
        hold_valid = 1'b0;
      end else if (bus_if.out_valid) begin
        hold_valid = 1'b1;
        held       = {bus_if.cout, bus_if.sum};
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  // Random downstream ready during the random phase
  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1;
      bus_if.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0008, 1'b0};
    vecs[1] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0001_0000_0000, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b1};
    vecs[3] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0};
    vecs[4] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1};
    vecs[6] = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0000, 1'b1};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   rsum;
    int           waited;

    bus_if.in_valid  = 1'b0;
    bus_if.row_a     = '0;
    bus_if.row_b     = '0;
    bus_if.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("reset_out_valid", {{W{1'b0}}, bus_if.out_valid}, '0);
    chk("reset_in_ready", {{W{1'b0}}, bus_if.in_ready}, {{W{1'b0}}, 1'b1});
    idle(2);
    rst = 1'b0;
    idle(1);

    // Basic pair with latency: empty right after accept, valid one edge later
    send_pair(vecs[0].a, vecs[0].b, {vecs[0].c, vecs[0].s});
    chk("lat_after_accept", {{W{1'b0}}, bus_if.out_valid}, '0);
    @(posedge clk); #1;
    chk("lat_next_edge", {{W{1'b0}}, bus_if.out_valid}, {{W{1'b0}}, 1'b1});
    idle(2);

    // Remaining vectors back to back
    for (int i = 1; i < 8; i++)
      send_pair(vecs[i].a, vecs[i].b, {vecs[i].c, vecs[i].s});
    idle(4);

    // Backpressure: two pairs fill the pipe, the third is refused
    bus_if.out_ready = 1'b0;
    send_pair(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, {1'b0, 64'h0000_0000_0000_0030});
    send_pair(64'h0000_0001_0000_0001, 64'h0000_0002_0000_0002, {1'b0, 64'h0000_0003_0000_0003});
    bus_if.in_valid = 1'b1;
    bus_if.row_a    = 64'h1234_5678_9ABC_DEF0;
    bus_if.row_b    = 64'h0FED_CBA9_8765_4321;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {{W{1'b0}}, bus_if.in_ready}, '0);
    end
    @(posedge clk); #1;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {{W{1'b0}}, bus_if.in_ready}, {{W{1'b0}}, 1'b1});
    exp_q.push_back({1'b0, 64'h2222_2222_2222_2211});
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_no_bubble", {{W{1'b0}}, bus_if.out_valid}, {{W{1'b0}}, 1'b1});
      @(posedge clk); #1;
    end
    idle(3);
    chk("bp_drained", W'(exp_q.size()) , '0);

    // Reset mid-flight with two pairs stored
    bus_if.out_ready = 1'b0;
    send_pair(64'h1, 64'h2, {1'b0, 64'h3});
    send_pair(64'h4, 64'h5, {1'b0, 64'h9});
    #3;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {{W{1'b0}}, bus_if.out_valid}, '0);
    chk("rst_in_ready", {{W{1'b0}}, bus_if.in_ready}, {{W{1'b0}}, 1'b1});
    exp_q.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_stale", {{W{1'b0}}, bus_if.out_valid}, '0);
    end
    @(posedge clk); #1;
    send_pair(vecs[2].a, vecs[2].b, {vecs[2].c, vecs[2].s});
    idle(4);

    // Random stream with random gaps and random downstream ready
    rand_ready_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rsum = {1'b0, ra} + {1'b0, rb};
      if ($urandom_range(0, 3) == 0) idle(1);
      send_pair(ra, rb, rsum);
    end
    rand_ready_en = 1'b0;
    @(posedge clk); #2;
    bus_if.out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("final_drain", W'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
